// File: rtl/bullet_collision_scanner.sv
// rtl/bullet_collision_scanner.sv - per-frame enemy-bullet vs player hitbox scanner
module bullet_collision_scanner #(
  parameter int N_SLOTS   = 32,
  parameter int COORD_W   = 10,
  parameter int HIT_RANGE = 5,
  localparam int AW       = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1
) (
  input  logic               clk,
  input  logic               hard_reset_n,
  input  logic               game_en,
  input  logic               game_reset,
  input  logic               frame_tick,
  input  logic               invuln,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  output logic [AW-1:0]      slot_addr,
  output logic               slot_rd,
  input  logic               slot_valid,
  input  logic [COORD_W-1:0] slot_x,
  input  logic [COORD_W-1:0] slot_y,
  output logic               collision,
  output logic               hit_clear,
  output logic [AW-1:0]      hit_slot,
  output logic               busy,
  output logic [7:0]         overrun_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_REPORT} state_e;

  localparam logic [COORD_W:0] HIT_R    = (COORD_W+1)'(HIT_RANGE);
  localparam logic [AW-1:0]    LAST_IDX = AW'(N_SLOTS - 1);

  state_e             state_q, state_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic               cmp_vld_q, cmp_vld_d;
  logic [AW-1:0]      cmp_idx_q, cmp_idx_d;
  logic               hit_found_q, hit_found_d;
  logic [AW-1:0]      hit_idx_q, hit_idx_d;
  logic [AW-1:0]      hit_slot_q, hit_slot_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
  logic               inv_q, inv_d;
  logic               en_q, en_d;
  logic [7:0]         ovr_q, ovr_d;

  logic [COORD_W:0]   dx, dy, adx, ady;
  logic               hit_now;
  logic               report;

  // Distance test on the slot data returned for the previous cycle's address.
  // One extra bit keeps the difference from wrapping at the coordinate limits.
  always_comb begin
    dx      = {1'b0, px_q} - {1'b0, slot_x};
    dy      = {1'b0, py_q} - {1'b0, slot_y};
    adx     = dx[COORD_W] ? (~dx + (COORD_W+1)'(1)) : dx;
    ady     = dy[COORD_W] ? (~dy + (COORD_W+1)'(1)) : dy;
    hit_now = cmp_vld_q && slot_valid && (adx <= HIT_R) && (ady <= HIT_R);
  end

  // Report is gated by the live game_en so a mid-scan stop suppresses it.
  always_comb begin
    report      = (state_q == S_REPORT) && hit_found_q && !inv_q && en_q && game_en;
    collision   = report;
    hit_clear   = report;
    hit_slot    = report ? hit_idx_q : hit_slot_q;
    slot_rd     = (state_q == S_SCAN);
    slot_addr   = addr_q;
    busy        = (state_q != S_IDLE);
    overrun_cnt = ovr_q;
  end

  // Next-state logic: scan sequencing, first-hit capture, overrun counting.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmp_vld_d   = (state_q == S_SCAN);
    cmp_idx_d   = addr_q;
    hit_found_d = hit_found_q;
    hit_idx_d   = hit_idx_q;
    hit_slot_d  = hit_slot_q;
    px_d        = px_q;
    py_d        = py_q;
    inv_d       = inv_q;
    en_d        = en_q;
    ovr_d       = ovr_q;

    if (hit_now && !hit_found_q) begin
      hit_found_d = 1'b1;
      hit_idx_d   = cmp_idx_q;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick && game_en) begin
          state_d     = S_SCAN;
          addr_d      = '0;
          px_d        = player_x;
          py_d        = player_y;
          inv_d       = invuln;
          en_d        = game_en;
          hit_found_d = 1'b0;
          hit_idx_d   = '0;
        end
      end
      S_SCAN: begin
        addr_d = addr_q + AW'(1);
        if (addr_q == LAST_IDX) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        state_d = S_REPORT;
      end
      S_REPORT: begin
        state_d = S_IDLE;
        if (report) hit_slot_d = hit_idx_q;
      end
      default: state_d = S_IDLE;
    endcase

    if (frame_tick && (state_q != S_IDLE) && (ovr_q != 8'hFF)) ovr_d = ovr_q + 8'd1;
  end

  // State register; game_reset clears synchronously with the same effect as reset.
  always_ff @(posedge clk or negedge hard_reset_n) begin
    if (!hard_reset_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= '0;
      hit_found_q <= 1'b0;
      hit_idx_q   <= '0;
      hit_slot_q  <= '0;
      px_q        <= '0;
      py_q        <= '0;
      inv_q       <= 1'b0;
      en_q        <= 1'b0;
      ovr_q       <= '0;
    end else if (game_reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      cmp_vld_q   <= 1'b0;
      cmp_idx_q   <= '0;
      hit_found_q <= 1'b0;
      hit_idx_q   <= '0;
      hit_slot_q  <= '0;
      px_q        <= '0;
      py_q        <= '0;
      inv_q       <= 1'b0;
      en_q        <= 1'b0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmp_vld_q   <= cmp_vld_d;
      cmp_idx_q   <= cmp_idx_d;
      hit_found_q <= hit_found_d;
      hit_idx_q   <= hit_idx_d;
      hit_slot_q  <= hit_slot_d;
      px_q        <= px_d;
      py_q        <= py_d;
      inv_q       <= inv_d;
      en_q        <= en_d;
      ovr_q       <= ovr_d;
    end
  end

endmodule

// File: tb/tb_bullet_collision_scanner.sv
// tb/tb_bullet_collision_scanner.sv - scoreboard bench for bullet_collision_scanner
module tb_bullet_collision_scanner;

  localparam int N  = 32;
  localparam int HR = 5;

  logic       clk = 1'b0;
  logic       hard_reset_n = 1'b0;
  logic       game_en = 1'b0;
  logic       game_reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       invuln = 1'b0;
  logic [9:0] player_x = '0;
  logic [9:0] player_y = '0;
  logic [4:0] slot_addr;
  logic       slot_rd;
  logic       slot_valid = 1'b0;
  logic [9:0] slot_x = '0;
  logic [9:0] slot_y = '0;
  logic       collision;
  logic       hit_clear;
  logic [4:0] hit_slot;
  logic       busy;
  logic [7:0] overrun_cnt;

  bullet_collision_scanner #(.N_SLOTS(N), .COORD_W(10), .HIT_RANGE(HR)) dut (
    .clk(clk), .hard_reset_n(hard_reset_n), .game_en(game_en), .game_reset(game_reset),
    .frame_tick(frame_tick), .invuln(invuln), .player_x(player_x), .player_y(player_y),
    .slot_addr(slot_addr), .slot_rd(slot_rd), .slot_valid(slot_valid), .slot_x(slot_x),
    .slot_y(slot_y), .collision(collision), .hit_clear(hit_clear), .hit_slot(hit_slot),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {int slot; int te;} exp_t;
  exp_t exp_q[$];

  bit         mem_v[N];
  logic [9:0] mem_x[N];
  logic [9:0] mem_y[N];

  always @(posedge clk) cyc <= cyc + 1;

  // Bullet store model: synchronous read, one cycle latency.
  always @(posedge clk) begin
    if (slot_rd) begin
      slot_valid <= mem_v[slot_addr];
      slot_x     <= mem_x[slot_addr];
      slot_y     <= mem_y[slot_addr];
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int absi(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic int clampc(input int a);
    return (a < 0) ? 0 : ((a > 1023) ? 1023 : a);
  endfunction

  // Monitor: every pulse must match the oldest expected report.
  bit col_prev = 1'b0;
  always @(negedge clk) begin
    if (collision || hit_clear) chk("clear_eq_collision", hit_clear, collision);
    if (collision && col_prev) chk("pulse_width", 2, 1);
    if (collision) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_collision_slot", hit_slot, -1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("hit_slot", hit_slot, e.slot);
        chk("latency", cyc - e.te, N + 1);
      end
    end
    col_prev = collision;
  end

  task automatic clear_mem();
    for (int i = 0; i < N; i++) begin
      mem_v[i] = 1'b0;
      mem_x[i] = 10'($urandom_range(0, 1023));
      mem_y[i] = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic set_slot(input int i, input bit v, input int x, input int y);
    mem_v[i] = v;
    mem_x[i] = 10'(x);
    mem_y[i] = 10'(y);
  endtask

  task automatic pulse_tick(output int te);
    @(posedge clk);
    #1 frame_tick = 1'b1;
    te = cyc + 1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
  endtask

  // One frame: model computes the lowest-index hit from the slot table,
  // optional mid-scan changes to invuln/player/game_en must not alter the scan.
  task automatic frame(input int px, input int py, input bit inv, input bit mid,
                       input int px2, input int py2, input bit inv2, input bit en2);
    int idx;
    int te;
    player_x = 10'(px);
    player_y = 10'(py);
    invuln   = inv;
    game_en  = 1'b1;
    idx = -1;
    for (int i = 0; i < N; i++) begin
      if (idx < 0 && mem_v[i] && absi(px - int'(mem_x[i])) <= HR && absi(py - int'(mem_y[i])) <= HR)
        idx = i;
    end
    pulse_tick(te);
    if (idx >= 0 && !inv && (!mid || en2)) exp_q.push_back('{slot: idx, te: te});
    chk("busy_start", busy, 1);
    repeat (10) @(posedge clk);
    if (mid) begin
      #1;
      player_x = 10'(px2);
      player_y = 10'(py2);
      invuln   = inv2;
      game_en  = en2;
    end
    repeat (N - 9) @(posedge clk);
    #1 chk("busy_report", busy, 1);
    @(posedge clk);
    #1 chk("busy_after", busy, 0);
    game_en = 1'b1;
    invuln  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int te;
    int last_acc;
    int drops;

    clear_mem();
    #23;
    chk("rst_collision", collision, 0);
    chk("rst_hit_clear", hit_clear, 0);
    chk("rst_hit_slot", hit_slot, 0);
    chk("rst_slot_addr", slot_addr, 0);
    chk("rst_slot_rd", slot_rd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun_cnt, 0);
    @(negedge clk) hard_reset_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single hit at slot 7
    set_slot(7, 1, 104, 96);
    frame(100, 100, 0, 0, 0, 0, 0, 1);

    // Lowest index wins; exact-range boundary
    clear_mem();
    set_slot(3, 1, 95, 105);
    set_slot(20, 1, 101, 99);
    frame(100, 100, 0, 0, 0, 0, 0, 1);
    set_slot(3, 1, 106, 100);
    frame(100, 100, 0, 0, 0, 0, 0, 1);
    set_slot(3, 1, 100, 94);
    frame(100, 100, 0, 0, 0, 0, 0, 1);

    // invuln latched at start, player/game_en changes mid-scan
    clear_mem();
    set_slot(7, 1, 104, 96);
    frame(100, 100, 1, 1, 100, 100, 0, 1);
    frame(100, 100, 0, 0, 0, 0, 0, 1);
    frame(100, 100, 0, 1, 600, 600, 1, 1);
    frame(100, 100, 0, 1, 100, 100, 0, 0);

    // game_en low at tick: no scan starts
    game_en = 1'b0;
    pulse_tick(te);
    chk("no_scan_when_disabled", busy, 0);
    game_en = 1'b1;

    // Coordinate limits and last-slot (drain-cycle) compare
    clear_mem();
    set_slot(0, 1, 1023, 1023);
    frame(0, 0, 0, 0, 0, 0, 0, 1);
    frame(1020, 1020, 0, 0, 0, 0, 0, 1);
    clear_mem();
    set_slot(N - 1, 1, 0, 5);
    frame(5, 0, 0, 0, 0, 0, 0, 1);
    set_slot(N - 1, 1, 1023, 0);
    frame(0, 1023, 0, 0, 0, 0, 0, 1);

    // Randomized frames
    for (int r = 0; r < 40; r++) begin
      int px, py;
      clear_mem();
      px = $urandom_range(0, 1023);
      py = $urandom_range(0, 1023);
      if (r % 5 == 0) px = (r % 10 == 0) ? 0 : 1023;
      if (r % 7 == 0) py = (r % 14 == 0) ? 1023 : 0;
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_slot(i, $urandom_range(0, 3) != 0,
                   clampc(px + int'($urandom_range(0, 16)) - 8),
                   clampc(py + int'($urandom_range(0, 16)) - 8));
        else
          set_slot(i, $urandom_range(0, 1) == 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
      end
      frame(px, py, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1023), $urandom_range(0, 1023),
            $urandom_range(0, 1) == 1, $urandom_range(0, 5) != 0);
    end

    chk("overrun_before", overrun_cnt, 0);

    // Ticks every 20 cycles: a tick is accepted only once the previous scan has ended
    clear_mem();
    game_en  = 1'b1;
    last_acc = -100000;
    drops    = 0;
    for (int k = 0; k < 640; k++) begin
      pulse_tick(te);
      if (te >= last_acc + N + 3) last_acc = te;
      else if (drops < 255) drops++;
      if (k == 20) begin
        #1 chk("overrun_mid", overrun_cnt, drops);
      end
      repeat (18) @(posedge clk);
    end
    repeat (40) @(posedge clk);
    #1 chk("overrun_sat", overrun_cnt, drops);
    chk("overrun_sat_const", overrun_cnt, 255);

    // game_reset mid-scan with a pending hit
    set_slot(7, 1, 104, 96);
    player_x = 10'd100;
    player_y = 10'd100;
    pulse_tick(te);
    repeat (12) @(posedge clk);
    #1 game_reset = 1'b1;
    @(posedge clk);
    #1 game_reset = 1'b0;
    chk("greset_busy", busy, 0);
    chk("greset_overrun", overrun_cnt, 0);
    chk("greset_collision", collision, 0);
    chk("greset_hit_slot", hit_slot, 0);
    chk("greset_slot_rd", slot_rd, 0);
    repeat (45) @(posedge clk);
    frame(100, 100, 0, 0, 0, 0, 0, 1);

    // Async reset during SCAN
    pulse_tick(te);
    repeat (4) @(posedge clk);
    #1 frame_tick = 1'b1;
    @(posedge clk);
    #1 frame_tick = 1'b0;
    chk("overrun_one", overrun_cnt, 1);
    repeat (3) @(posedge clk);
    #3 hard_reset_n = 1'b0;
    #1;
    chk("areset_busy", busy, 0);
    chk("areset_slot_rd", slot_rd, 0);
    chk("areset_slot_addr", slot_addr, 0);
    chk("areset_collision", collision, 0);
    chk("areset_hit_clear", hit_clear, 0);
    chk("areset_hit_slot", hit_slot, 0);
    chk("areset_overrun", overrun_cnt, 0);
    @(negedge clk) hard_reset_n = 1'b1;
    repeat (45) @(posedge clk);
    frame(100, 100, 0, 0, 0, 0, 0, 1);

    repeat (5) @(posedge clk);
    chk("pending_reports", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bullet_collision_scanner.md
Name: bullet_collision_scanner

Overview:
- Upstream of the game-state FSM. Produces the one-cycle `collision` pulse that the FSM consumes.
- Once per video frame it walks the enemy-bullet slot table. Each slot is read through a synchronous read port with 1-cycle latency.
- It tests every valid bullet for box overlap against the player hitbox and reports the lowest-index hit.
- On a hit it also issues a clear pulse so the bullet store can free that slot.

Parameters:
- N_SLOTS, 32, number of bullet slots scanned per frame. Power of two, 2 to 256.
- COORD_W, 10, width of the x/y coordinates (unsigned pixels).
- HIT_RANGE, 5, overlap threshold. Hit when |dx| <= HIT_RANGE and |dy| <= HIT_RANGE. Equals the player half-size plus the bullet half-size.

Ports:
- clk  in  1  system clock
- hard_reset_n  in  1  asynchronous active-low reset
- game_en  in  1  game running; scans start only when high
- game_reset  in  1  synchronous clear, same priority as reset but synchronous
- frame_tick  in  1  one-cycle pulse, start of frame
- invuln  in  1  FSM is in Collision/Bomb state; hits are suppressed
- player_x  in  COORD_W  player centre x
- player_y  in  COORD_W  player centre y
- slot_addr  out  log2(N_SLOTS)  bullet table read address
- slot_rd  out  1  read strobe
- slot_valid  in  1  slot occupied (1-cycle read latency)
- slot_x  in  COORD_W  bullet x (1-cycle read latency)
- slot_y  in  COORD_W  bullet y (1-cycle read latency)
- collision  out  1  one-cycle hit pulse to the FSM
- hit_clear  out  1  one-cycle pulse, coincident with collision
- hit_slot  out  log2(N_SLOTS)  index of the reported hit, held until the next report
- busy  out  1  scan in progress
- overrun_cnt  out  8  saturating count of frame_tick pulses dropped while busy

Behaviour:
- Reset (async, hard_reset_n low):
  - Outputs: collision=0, hit_clear=0, hit_slot=0, slot_addr=0, slot_rd=0, busy=0, overrun_cnt=0.
  - State: IDLE.
- game_reset=1: the same clears take effect at the next clk edge, with priority over all other logic. An in-flight scan is aborted with no report.
- States: IDLE, SCAN, DRAIN, REPORT.
- IDLE:
  - Transition: on frame_tick && game_en, go to SCAN.
  - Latched at that edge: player_x, player_y, invuln and game_en.
  - Registers cleared: the hit_found flag and the hit-index register.
- SCAN:
  - slot_rd=1 each cycle.
  - slot_addr is registered: 0 in the first SCAN cycle, then +1 per cycle.
  - After address N_SLOTS-1 has been issued, go to DRAIN.
- Compare (runs on the data returned one cycle after each address):
  - Form dx = player_x - slot_x in COORD_W+1 bits, two's complement, then take the absolute value; dy the same way.
  - Hit when slot_valid && |dx| <= HIT_RANGE && |dy| <= HIT_RANGE.
  - The first hit sets hit_found and stores the index. Later hits are ignored (lowest index wins).
- DRAIN: one cycle, slot_rd=0. The data for slot N_SLOTS-1 is compared here. Then go to REPORT.
- REPORT: one cycle.
  - If hit_found && !invuln_latched && game_en (live value): assert collision=1 and hit_clear=1, and load hit_slot.
  - Otherwise no pulse.
  - Next state: IDLE.
- Timing:
  - For a tick sampled at edge T: addresses are issued at T+1 through T+N_SLOTS, and collision is high during cycle T+N_SLOTS+2.
  - busy=1 from T+1 through the REPORT cycle.
  - A new tick is accepted on the first IDLE cycle after REPORT.
- frame_tick while not IDLE: ignored; overrun_cnt increments and saturates at 255.
- game_en falling mid-scan: the scan completes but the report is suppressed.
- invuln changing mid-scan: no effect (the value latched at start is used).
- Player coordinates changing mid-scan: no effect (the latched values are used).
- collision and hit_clear are never high for more than one consecutive cycle.
- At most one report per frame.
- Coordinate boundaries: dx/dy at 0 and at the COORD_W limits must not wrap.
  - Example: player_x=0, slot_x=1023 gives |dx|=1023, which is no hit.

Test Plan:
1. Reset, game_en=1, player=(100,100), slot 7 valid at (104,96), all others invalid, tick -> collision=1, hit_clear=1, hit_slot=7 exactly 34 cycles after the tick edge; busy low the next cycle.
2. Slots 3 and 20 valid and in range, slot 3 at distance exactly 5 -> single pulse with hit_slot=3. Move slot 3 to distance 6 -> hit_slot=20.
3. Same hit as scenario 1 with invuln=1 at the tick, then invuln deasserted mid-scan -> no collision. Next frame with invuln=0 -> collision pulse.
4. frame_tick every 20 cycles -> every other tick is dropped and overrun_cnt increments; after 300 drops it stays at 255.
5. player=(0,0), bullet at (1023,1023) valid -> no collision. player=(1020,1020), bullet (1023,1023) -> collision.
6. game_reset pulsed mid-scan with a pending hit -> no collision, busy=0, overrun_cnt=0 on the next cycle. Async reset during SCAN -> all outputs 0 immediately.
